// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, bus widths and the reset instruction.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  localparam int CPU_AW     = 32;
  localparam int CPU_DW     = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // A word address has its two byte-offset bits clear.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: req/ready request phase, rvalid/rdata response phase.
interface instr_fetch_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Request: mem_addr is stable while mem_req=1; the request is taken in the
    // cycle where mem_req=1 and mem_ready=1. Response: one cycle of mem_rvalid=1
    // carries mem_rdata, and it only counts after the request has been taken.
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_timer.sv
// Saturating cycle counter with clear, load and enable; tc flags the last allowed cycle.
module fetch_timer #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          tc
);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Clear has priority so a fresh request always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads one word at pc_q, loads the IR and pulses PC write with PC+4.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int AW      = CPU_AW,
    parameter int DW      = CPU_DW,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic [AW-1:0]     pc_q,
    instr_fetch_if.master     bus,
    output logic [DW-1:0]     ir,
    output logic [AW-1:0]     npc,
    output logic              pc_wr,
    output logic              fetch_done,
    output logic              busy,
    output logic              fetch_err,
    output fetch_state_e      state_dbg
);
    localparam int CW = $clog2(TIMEOUT);

    fetch_state_e  state;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic          can_start;
    logic          aligned;
    logic          start_ok;
    logic          tmr_en;
    logic          tmr_tc;

    assign can_start = (state == IDLE) || (state == ERR);
    assign aligned   = is_word_aligned(pc_q[1:0]);
    assign start_ok  = can_start && fetch_start && aligned;
    assign tmr_en    = (state == REQ) || (state == WAIT);

    fetch_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    // Progress (ready in REQ, rvalid in WAIT) is tested before the timer so it wins ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            ir         <= DW'(INSTR_NOP);
            npc        <= '0;
            pc_wr      <= 1'b0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            pc_wr      <= 1'b0;
            fetch_done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (fetch_start) begin
                        if (!aligned) begin
                            state     <= ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state     <= REQ;
                            fetch_err <= 1'b0;
                            addr_q    <= pc_q;
                            req_q     <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                    end else if (tmr_tc) begin
                        state     <= ERR;
                        req_q     <= 1'b0;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state      <= DONE;
                        ir         <= bus.mem_rdata;
                        npc        <= addr_q + AW'(WORD_BYTES);
                        pc_wr      <= 1'b1;
                        fetch_done <= 1'b1;
                    end else if (tmr_tc) begin
                        state     <= ERR;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fixed cycle-by-cycle stimulus with hand-computed checks.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          fetch_start;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir;
  logic [AW-1:0] npc;
  logic          pc_wr;
  logic          fetch_done;
  logic          busy;
  logic          fetch_err;
  fetch_state_e  state_dbg;

  int total = 0;
  int bad   = 0;
  int pw_cnt = 0;
  int pw_before;

  instr_fetch_if #(.AW(AW), .DW(DW)) bus ();

  instr_fetch #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_start (fetch_start),
    .pc_q        (pc_q),
    .bus         (bus.master),
    .ir          (ir),
    .npc         (npc),
    .pc_wr       (pc_wr),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle and sample just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    if (pc_wr === 1'b1) pw_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_start = 1'b0;
    pc_q = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    cyc();
    cyc();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_npc", npc, 32'h0);
    chk("rst_pulses", {pc_wr, fetch_done, busy, fetch_err}, 4'b0000);
    chk("rst_state", state_dbg, IDLE);
    rst_n = 1'b1;
    cyc();

    // basic fetch, minimum latency
    pc_q = 32'h0000_0040;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("basic_c1_req", bus.mem_req, 1'b1);
    chk("basic_c1_addr", bus.mem_addr, 32'h0000_0040);
    chk("basic_c1_busy_pw", {busy, pc_wr, fetch_done}, 3'b100);
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    chk("basic_c2_req", bus.mem_req, 1'b0);
    chk("basic_c2_state", state_dbg, WAIT);
    chk("basic_c2_pw", {pc_wr, fetch_done}, 2'b00);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h8C01_0004;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("basic_c3_pulses", {pc_wr, fetch_done, busy}, 3'b111);
    chk("basic_c3_ir", ir, 32'h8C01_0004);
    chk("basic_c3_npc", npc, 32'h0000_0044);
    cyc();
    chk("basic_c4_pulses", {pc_wr, fetch_done, busy}, 3'b000);
    chk("basic_c4_state", state_dbg, IDLE);
    chk("basic_c4_ir_hold", ir, 32'h8C01_0004);

    // reset asserted in the middle of a request
    pc_q = 32'h0000_0100;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("midrst_req_before", bus.mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_now", bus.mem_req, 1'b0);
    chk("midrst_addr", bus.mem_addr, 32'h0);
    chk("midrst_ir", ir, 32'h0);
    chk("midrst_npc", npc, 32'h0);
    chk("midrst_flags", {pc_wr, fetch_done, busy, fetch_err}, 4'b0000);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("midrst_state", state_dbg, IDLE);

    // wait states, busy-time fetch_start, rvalid coinciding with ready
    pw_before = pw_cnt;
    pc_q = 32'h0000_0200;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_req_hold", {bus.mem_req, busy}, 2'b11);
      chk("ws_req_addr", bus.mem_addr, 32'h0000_0200);
      cyc();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    chk("ws_ready_addr", bus.mem_addr, 32'h0000_0200);
    cyc();
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_start = (i == 0);
      pc_q = 32'h0000_0300;
      chk("ws_wait_state", state_dbg, WAIT);
      chk("ws_wait_busy_req", {busy, bus.mem_req}, 2'b10);
      chk("ws_wait_addr", bus.mem_addr, 32'h0000_0200);
      cyc();
    end
    fetch_start = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("ws_done_ir", ir, 32'h1234_5678);
    chk("ws_done_npc", npc, 32'h0000_0204);
    cyc();
    cyc();
    chk("ws_one_pc_wr", pw_cnt - pw_before, 1);
    chk("ws_idle", state_dbg, IDLE);

    // address wrap
    pc_q = 32'hFFFF_FFFC;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hAABB_CCDD;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("wrap_npc", npc, 32'h0000_0000);
    chk("wrap_ir", ir, 32'hAABB_CCDD);
    cyc();

    // misaligned PC
    pc_q = 32'h0000_0042;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("mis_err", fetch_err, 1'b1);
    chk("mis_state", state_dbg, ERR);
    chk("mis_busy", busy, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("mis_no_req", bus.mem_req, 1'b0);
      cyc();
    end
    chk("mis_err_sticky", fetch_err, 1'b1);
    chk("mis_ir_hold", ir, 32'hAABB_CCDD);

    // restart from ERR, then timeout with mem_ready held low
    pc_q = 32'h0000_0080;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("to_restart_err", fetch_err, 1'b0);
    chk("to_restart_req", bus.mem_req, 1'b1);
    chk("to_restart_addr", bus.mem_addr, 32'h0000_0080);
    repeat (15) cyc();
    chk("to_c16_still_req", state_dbg, REQ);
    cyc();
    chk("to_err_state", state_dbg, ERR);
    chk("to_err_flag", fetch_err, 1'b1);
    chk("to_req_drop", {bus.mem_req, busy, pc_wr}, 3'b000);
    chk("to_ir_hold", ir, 32'hAABB_CCDD);
    chk("to_npc_hold", npc, 32'h0000_0000);
    pc_q = 32'h0000_0040;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("to_clear_err", fetch_err, 1'b0);
    chk("to_reenter_req", {bus.mem_req, state_dbg == REQ}, 2'b11);
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0000_1111;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("to_refetch_done", {fetch_done, pc_wr}, 2'b11);
    chk("to_refetch_npc", npc, 32'h0000_0044);
    cyc();

    // progress on the last allowed cycle wins over the timeout
    pc_q = 32'h0000_0400;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    repeat (15) cyc();
    chk("edge_c16_req", state_dbg, REQ);
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    chk("edge_wait", state_dbg, WAIT);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("edge_done", state_dbg, DONE);
    chk("edge_ir", ir, 32'h0BAD_F00D);
    chk("edge_no_err", fetch_err, 1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
